game_countdown_timer: RTL and testbench
=======================================

// Module: game_countdown_timer
// PURPOSE
//  Consumer end of the 1 Hz tick: takes the one-cycle tick pulse from the 1 Hz divider and
//  counts the player's remaining time down from START_SECONDS.
//  Provides a start/pause/stop game-control interface and BCD seconds for the HEX displays.
//  Signals the game FSM with warning and time-up indications.
// PARAMETERS
//  START_SECONDS  99  load value on start; legal range 0..99
//  WARN_SECONDS   10  warning asserted while 0 < remaining <= WARN_SECONDS
//  BONUS_SECONDS  5   seconds added per bonus pulse (TIMER_BONUS_EN only)
// PORTS
//  clock          in   1  system clock (50 MHz)
//  reset          in   1  synchronous, active-high
//  tick           in   1  1-cycle pulse, once per second, from the 1 Hz divider
//  start          in   1  pulse; (re)load START_SECONDS and run
//  pause          in   1  level; while high, ticks are ignored
//  stop           in   1  pulse; player reached exit, freeze remaining time
//  bonus          in   1  pulse; add BONUS_SECONDS (port exists only with TIMER_BONUS_EN)
//  secs_tens      out  4  BCD tens digit of remaining time
//  secs_ones      out  4  BCD ones digit of remaining time
//  running        out  1  high in RUNNING
//  warning        out  1  high in RUNNING/PAUSED when 0 < remaining <= WARN_SECONDS
//  time_up        out  1  level, high in EXPIRED
//  expired_pulse  out  1  1-cycle pulse on entry to EXPIRED
// BEHAVIOUR
//  - Internal remaining count: 7-bit binary register, 0..99; BCD outputs decoded from it.
//  - Reset: state IDLE; count = START_SECONDS; running/warning/time_up/expired_pulse = 0.
//  - States: IDLE, RUNNING, PAUSED, FROZEN, EXPIRED.
//  - IDLE: start -> RUNNING, count reloaded. Ticks ignored.
//  - RUNNING: tick -> count-1 (registered; visible the cycle after tick).
//    pause high -> PAUSED. stop -> FROZEN. A tick taking count 1 -> 0 -> EXPIRED.
//  - PAUSED: ticks dropped, never queued. pause low -> RUNNING. stop -> FROZEN.
//  - FROZEN/EXPIRED: count held. start -> RUNNING with reload. All other inputs ignored.
//  - EXPIRED entry: time_up rises and expired_pulse is high for exactly that one cycle,
//    i.e. the cycle after the final tick.
//  - start while RUNNING/PAUSED is ignored; no mid-game restart. Use reset to abort.
//  - Same-cycle priority in RUNNING: stop > pause > tick.
//    tick with pause high is dropped. tick with stop freezes the pre-tick value.
//  - START_SECONDS = 0: start goes directly to EXPIRED, with expired_pulse.
//  - Count never wraps below 0. Reset mid-game returns to IDLE on the next edge.
// CONFIGURATION
//  - TIMER_BONUS_EN defined: bonus port present; honoured in RUNNING and PAUSED.
//    Count += BONUS_SECONDS, saturating at 99.
//    bonus+tick in the same cycle nets +BONUS_SECONDS-1 (saturate after the sum).
//    bonus ignored in IDLE/FROZEN/EXPIRED and in the cycle the count reaches 0.
//  - TIMER_BONUS_EN undefined: no bonus port, no adder; count only decrements.
// STRUCTURE
//  - Shared defs include (game_timer_defs.vh): state encodings (3-bit localparams),
//    MAX_SECONDS = 99, BCD width = 4.
//  - One sub-module: bin_to_bcd99 (combinational 7-bit binary -> tens/ones BCD),
//    reused by the score display.
//  - Top: state register + count register + warning compare.
// TESTING
//  1. reset; start; 99 ticks with START_SECONDS=99 -> digits 9,9 ... 0,0;
//     time_up=1 and expired_pulse high 1 cycle after tick 99.
//  2. RUNNING at 42; pause=1; 3 ticks; pause=0; 1 tick -> 42 held, then 41.
//  3. RUNNING at 30; stop and tick same cycle -> FROZEN at 30; further ticks -> still 30.
//  4. START_SECONDS=12, WARN_SECONDS=10: warning 0 at 11, 1 at 10..1, 0 at 0 with time_up=1.
//  5. EXPIRED; start -> count 99, RUNNING, time_up=0. start while RUNNING at 50 -> stays 50.
//  6. TIMER_BONUS_EN: bonus at 97 -> 99 (saturate); bonus+tick at 40 -> 44; bonus in FROZEN -> unchanged.

Source files
------------

// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the game countdown timer: FSM states, limits, saturating helper.
// The bonus path is built only when TIMER_BONUS_EN is defined.
package game_countdown_timer_pkg;

   localparam int unsigned MAX_SECONDS = 99;
   localparam int unsigned BCD_W       = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUNNING = 3'd1,
      PAUSED  = 3'd2,
      FROZEN  = 3'd3,
      EXPIRED = 3'd4
   } timer_state_t;

   // Clamp an 8-bit intermediate sum back into the 0..99 count range.
   function automatic logic [6:0] sat99(input logic [7:0] v);
      if (v > 8'(MAX_SECONDS))
         return 7'(MAX_SECONDS);
      else
         return v[6:0];
   endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Game-control and display bundle between the game FSM (master) and the timer (slave).
// The bonus signal exists only when TIMER_BONUS_EN is defined.
interface game_countdown_timer_if;
   import game_countdown_timer_pkg::*;

   logic             tick;
   logic             start;
   logic             pause;
   logic             stop;
`ifdef TIMER_BONUS_EN
   logic             bonus;
`endif
   logic [BCD_W-1:0] secs_tens;
   logic [BCD_W-1:0] secs_ones;
   logic             running;
   logic             warning;
   logic             time_up;
   logic             expired_pulse;

`ifdef TIMER_BONUS_EN
   modport master (output tick, start, pause, stop, bonus,
                   input  secs_tens, secs_ones, running, warning, time_up, expired_pulse);
   modport slave  (input  tick, start, pause, stop, bonus,
                   output secs_tens, secs_ones, running, warning, time_up, expired_pulse);
`else
   modport master (output tick, start, pause, stop,
                   input  secs_tens, secs_ones, running, warning, time_up, expired_pulse);
   modport slave  (input  tick, start, pause, stop,
                   output secs_tens, secs_ones, running, warning, time_up, expired_pulse);
`endif

endinterface

// File: rtl/game_countdown_timer_bin_to_bcd99.sv
// Combinational 7-bit binary (0..99) to two BCD digits; shared with the score display.
module bin_to_bcd99
   import game_countdown_timer_pkg::*;
(
   input  logic [6:0]       bin,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   always_comb begin
      tens = '0;
      for (int unsigned i = 1; i <= 9; i++) begin
         if (bin >= 7'(10 * i))
            tens = 4'(i);
      end
      ones = 4'(bin - 7'(tens * 10));
   end

endmodule

// File: rtl/game_countdown_timer.sv
// Countdown of remaining game time driven by the 1 Hz tick, with pause/stop/expire states.
// Optional TIMER_BONUS_EN adds the bonus input and saturating add path.
module game_countdown_timer
   import game_countdown_timer_pkg::*;
#(
   parameter int unsigned START_SECONDS = 99,
   parameter int unsigned WARN_SECONDS  = 10
`ifdef TIMER_BONUS_EN
   ,
   parameter int unsigned BONUS_SECONDS = 5
`endif
)
(
   input logic clock,
   input logic reset,
   game_countdown_timer_if.slave bus
);

   timer_state_t state, state_n;
   logic [6:0]   count, count_n;
   logic         enter_exp;
   logic         expired_pulse_q;
`ifdef TIMER_BONUS_EN
   logic [7:0]   bonus_add;
   assign bonus_add = bus.bonus ? 8'(BONUS_SECONDS) : '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         count           <= 7'(START_SECONDS);
         expired_pulse_q <= 1'b0;
      end else begin
         state           <= state_n;
         count           <= count_n;
         expired_pulse_q <= enter_exp;
      end
   end

   always_comb begin
      state_n   = state;
      count_n   = count;
      enter_exp = 1'b0;
      case (state)
         IDLE, FROZEN, EXPIRED: begin
            if (bus.start) begin
               if (START_SECONDS == 0) begin
                  state_n   = EXPIRED;
                  count_n   = '0;
                  enter_exp = 1'b1;
               end else begin
                  state_n = RUNNING;
                  count_n = 7'(START_SECONDS);
               end
            end
         end
         RUNNING: begin
            if (bus.stop) begin
               state_n = FROZEN;
            end else if (bus.pause) begin
               state_n = PAUSED;
`ifdef TIMER_BONUS_EN
               count_n = sat99({1'b0, count} + bonus_add);
`endif
            end else if (bus.tick) begin
               // The final tick wins over a same-cycle bonus so expiry is never skipped.
               if (count <= 7'd1) begin
                  state_n   = EXPIRED;
                  count_n   = '0;
                  enter_exp = 1'b1;
               end else begin
`ifdef TIMER_BONUS_EN
                  count_n = sat99({1'b0, count} + bonus_add - 8'd1);
`else
                  count_n = count - 7'd1;
`endif
               end
            end else begin
`ifdef TIMER_BONUS_EN
               count_n = sat99({1'b0, count} + bonus_add);
`endif
            end
         end
         PAUSED: begin
            if (bus.stop) begin
               state_n = FROZEN;
            end else begin
               if (!bus.pause)
                  state_n = RUNNING;
`ifdef TIMER_BONUS_EN
               count_n = sat99({1'b0, count} + bonus_add);
`endif
            end
         end
         default: state_n = IDLE;
      endcase
   end

   bin_to_bcd99 u_bcd (
      .bin  (count),
      .tens (bus.secs_tens),
      .ones (bus.secs_ones)
   );

   assign bus.running       = (state == RUNNING);
   assign bus.time_up       = (state == EXPIRED);
   assign bus.expired_pulse = expired_pulse_q;
   assign bus.warning       = ((state == RUNNING) || (state == PAUSED)) &&
                              (count != 7'd0) && (count <= 7'(WARN_SECONDS));

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed self-checking bench for game_countdown_timer (default, START=12 and START=0 builds).
// Bonus steps run only when TIMER_BONUS_EN is defined.
module tb_game_countdown_timer;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #10 clock = ~clock;

   game_countdown_timer_if tif();
   game_countdown_timer_if tif12();
   game_countdown_timer_if tif0();

   game_countdown_timer dut (.clock(clock), .reset(reset), .bus(tif.slave));
   game_countdown_timer #(.START_SECONDS(12), .WARN_SECONDS(10))
      dut12 (.clock(clock), .reset(reset), .bus(tif12.slave));
   game_countdown_timer #(.START_SECONDS(0))
      dut0 (.clock(clock), .reset(reset), .bus(tif0.slave));

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_secs(input string tag, input int tens, input int ones, input int n);
      chk({tag, "_tens"}, tens, n / 10);
      chk({tag, "_ones"}, ones, n % 10);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tif.tick = 1'b1;
         step();
         tif.tick = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      {tif.tick, tif.start, tif.pause, tif.stop}         = '0;
      {tif12.tick, tif12.start, tif12.pause, tif12.stop} = '0;
      {tif0.tick, tif0.start, tif0.pause, tif0.stop}     = '0;
`ifdef TIMER_BONUS_EN
      tif.bonus = 1'b0; tif12.bonus = 1'b0; tif0.bonus = 1'b0;
`endif
      step(); step();
      reset = 1'b0;
      step();

      // Reset state
      chk_secs("rst", tif.secs_tens, tif.secs_ones, 99);
      chk("rst_running", tif.running, 0);
      chk("rst_warning", tif.warning, 0);
      chk("rst_time_up", tif.time_up, 0);
      chk("rst_pulse", tif.expired_pulse, 0);
      ticks(2);
      chk_secs("idle_tick", tif.secs_tens, tif.secs_ones, 99);

      // 1: full countdown
      tif.start = 1'b1; step(); tif.start = 1'b0;
      chk("t1_running", tif.running, 1);
      chk_secs("t1_start", tif.secs_tens, tif.secs_ones, 99);
      for (int i = 1; i <= 99; i++) begin
         tif.tick = 1'b1; step(); tif.tick = 1'b0;
         chk_secs("t1_cnt", tif.secs_tens, tif.secs_ones, 99 - i);
         if (i == 98) chk("t1_warn_at1", tif.warning, 1);
      end
      chk("t1_time_up", tif.time_up, 1);
      chk("t1_pulse", tif.expired_pulse, 1);
      chk("t1_warn_at0", tif.warning, 0);
      chk("t1_running_end", tif.running, 0);
      ticks(1);
      chk("t1_pulse_drop", tif.expired_pulse, 0);
      chk("t1_time_up_hold", tif.time_up, 1);
      chk_secs("t1_no_wrap", tif.secs_tens, tif.secs_ones, 0);

      // 5a: restart from EXPIRED
      tif.start = 1'b1; step(); tif.start = 1'b0;
      chk_secs("t5_reload", tif.secs_tens, tif.secs_ones, 99);
      chk("t5_running", tif.running, 1);
      chk("t5_time_up", tif.time_up, 0);

      // 2: pause at 42
      ticks(57);
      chk_secs("t2_at42", tif.secs_tens, tif.secs_ones, 42);
      tif.pause = 1'b1; step();
      chk("t2_paused", tif.running, 0);
      ticks(3);
      chk_secs("t2_held", tif.secs_tens, tif.secs_ones, 42);
      tif.pause = 1'b0; step();
      chk("t2_resumed", tif.running, 1);
      chk_secs("t2_resume_hold", tif.secs_tens, tif.secs_ones, 42);
      ticks(1);
      chk_secs("t2_41", tif.secs_tens, tif.secs_ones, 41);

      // 3: stop and tick together at 30
      ticks(11);
      chk_secs("t3_at30", tif.secs_tens, tif.secs_ones, 30);
      tif.stop = 1'b1; tif.tick = 1'b1; step(); tif.stop = 1'b0; tif.tick = 1'b0;
      chk_secs("t3_frozen", tif.secs_tens, tif.secs_ones, 30);
      chk("t3_running", tif.running, 0);
      ticks(3);
      chk_secs("t3_still30", tif.secs_tens, tif.secs_ones, 30);
      chk("t3_warn", tif.warning, 0);

      // 5b: start while RUNNING at 50 is ignored
      tif.start = 1'b1; step(); tif.start = 1'b0;
      chk_secs("t5_frozen_restart", tif.secs_tens, tif.secs_ones, 99);
      ticks(49);
      chk_secs("t5_at50", tif.secs_tens, tif.secs_ones, 50);
      tif.start = 1'b1; step(); tif.start = 1'b0;
      chk_secs("t5_no_restart", tif.secs_tens, tif.secs_ones, 50);
      chk("t5_still_running", tif.running, 1);

`ifdef TIMER_BONUS_EN
      // 6: bonus behaviour
      tif.stop = 1'b1; step(); tif.stop = 1'b0;
      tif.bonus = 1'b1; step(); tif.bonus = 1'b0;
      chk_secs("t6_frozen_bonus", tif.secs_tens, tif.secs_ones, 50);
      tif.start = 1'b1; step(); tif.start = 1'b0;
      ticks(2);
      chk_secs("t6_at97", tif.secs_tens, tif.secs_ones, 97);
      tif.bonus = 1'b1; step(); tif.bonus = 1'b0;
      chk_secs("t6_sat", tif.secs_tens, tif.secs_ones, 99);
      ticks(59);
      chk_secs("t6_at40", tif.secs_tens, tif.secs_ones, 40);
      tif.bonus = 1'b1; tif.tick = 1'b1; step(); tif.bonus = 1'b0; tif.tick = 1'b0;
      chk_secs("t6_bonus_tick", tif.secs_tens, tif.secs_ones, 44);
`endif

      // 4: warning window with START_SECONDS=12
      tif12.start = 1'b1; step(); tif12.start = 1'b0;
      chk_secs("t4_start", tif12.secs_tens, tif12.secs_ones, 12);
      chk("t4_warn12", tif12.warning, 0);
      tif12.tick = 1'b1; step(); tif12.tick = 1'b0;
      chk("t4_warn11", tif12.warning, 0);
      for (int n = 10; n >= 0; n--) begin
         tif12.tick = 1'b1; step(); tif12.tick = 1'b0;
         chk_secs("t4_cnt", tif12.secs_tens, tif12.secs_ones, n);
         chk("t4_warn", tif12.warning, (n > 0) ? 1 : 0);
      end
      chk("t4_time_up", tif12.time_up, 1);
      chk("t4_pulse", tif12.expired_pulse, 1);

      // START_SECONDS=0: start goes straight to EXPIRED
      chk("z_pre_time_up", tif0.time_up, 0);
      tif0.start = 1'b1; step(); tif0.start = 1'b0;
      chk("z_time_up", tif0.time_up, 1);
      chk("z_pulse", tif0.expired_pulse, 1);
      chk("z_running", tif0.running, 0);
      chk_secs("z_cnt", tif0.secs_tens, tif0.secs_ones, 0);
      step();
      chk("z_pulse_drop", tif0.expired_pulse, 0);

      // Mid-game reset returns to IDLE with the start value
      tif12.start = 1'b1; step(); tif12.start = 1'b0;
      ticks(3);
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst2_running", tif.running, 0);
      chk_secs("rst2_cnt", tif.secs_tens, tif.secs_ones, 99);
      chk("rst2_time_up12", tif12.time_up, 0);
      chk_secs("rst2_cnt12", tif12.secs_tens, tif12.secs_ones, 12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
